// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern blocks:
//   - pattern mode encodings (3-bit, values 5..7 are reserved)
//   - sequencer state encoding
//   - init_pat(): the first pattern shown for a given mode
// ---------------------------------------------------------------------------
package led_pkg;

    // Widest LED string init_pat() can describe; callers size-cast the result.
    localparam int LED_MAX = 64;

    localparam logic [2:0] MODE_SHIFT_UP = 3'd0;
    localparam logic [2:0] MODE_SHIFT_DN = 3'd1;
    localparam logic [2:0] MODE_PINGPONG = 3'd2;
    localparam logic [2:0] MODE_BAR      = 3'd3;
    localparam logic [2:0] MODE_BLINK    = 3'd4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Initial pattern for a mode on a string of led_num LEDs.
    // Reserved modes return all-off.
    function automatic logic [LED_MAX-1:0] init_pat(input logic [2:0] mode,
                                                     input int         led_num);
        logic [LED_MAX-1:0] p;
        p = '0;
        case (mode)
            MODE_SHIFT_UP,
            MODE_PINGPONG,
            MODE_BAR: p[0] = 1'b1;
            MODE_SHIFT_DN: begin
                for (int i = 0; i < LED_MAX; i++) begin
                    if (i == led_num - 1) p[i] = 1'b1;
                end
            end
            MODE_BLINK: begin
                for (int i = 0; i < LED_MAX; i++) begin
                    if (i < led_num) p[i] = 1'b1;
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_tick_div.sv
// ---------------------------------------------------------------------------
// led_tick_div
// Free-running prescaler producing a one-cycle tick every TICK_CNT enabled
// clocks. Reusable by any LED / blink block that needs a slow time base.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   clr_i   in   synchronous clear of the count (wins over en_i)
//   en_i    in   count enable
//   tick_o  out  high in the cycle the count equals TICK_CNT-1
// ---------------------------------------------------------------------------
module led_tick_div #(
    parameter int TICK_CNT = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CNT - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick_o = en_i && !clr_i && (cnt == CNT_LAST);

endmodule

// File: rtl/led_pattern_seq.sv
// ---------------------------------------------------------------------------
// led_pattern_seq
// Run-time selectable LED pattern sequencer: rotate up, rotate down,
// ping-pong, bar fill, blink. One pattern step every max(step_ticks_i,1)
// prescaler ticks.
//
// Ports:
//   clk           in   clock
//   rst_n         in   asynchronous active-low reset
//   en_i          in   1 = run, 0 = idle with all LEDs off
//   mode_i        in   pattern select (led_pkg MODE_*), 5..7 reserved
//   step_ticks_i  in   prescaler ticks per step, 0 behaves as 1
//   restart_i     in   single-cycle pulse, reload the initial pattern
//   led_o         out  LED drive, polarity set by LED_ON_MODE
//   step_o        out  one-cycle pulse on every pattern advance
//   wrap_o        out  one-cycle pulse when an advance returns to the start
// ---------------------------------------------------------------------------
module led_pattern_seq
    import led_pkg::*;
#(
    parameter int LED_NUM     = 8,
    parameter bit LED_ON_MODE = 1'b0,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TICK_US     = 1000,
    parameter int STEP_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [2:0]        mode_i,
    input  logic [STEP_W-1:0] step_ticks_i,
    input  logic              restart_i,
    output logic [LED_NUM-1:0] led_o,
    output logic              step_o,
    output logic              wrap_o
);

    localparam int TICK_CNT = CLK_FREQ / 1_000_000 * TICK_US;

    state_e               state;
    logic [LED_NUM-1:0]   pat;
    logic [STEP_W-1:0]    step_cnt;
    logic                 dir_down;
    logic [2:0]           mode_q;

    logic                 tick;
    logic                 reload;
    logic                 advance_due;
    logic                 mode_valid;
    logic [STEP_W-1:0]    step_last;
    logic [LED_NUM-1:0]   init_new;
    logic [LED_NUM-1:0]   init_cur;
    logic [LED_NUM-1:0]   next_pat;
    logic                 next_dir_down;

    assign init_new = LED_NUM'(init_pat(mode_i, LED_NUM));
    assign init_cur = LED_NUM'(init_pat(mode_q, LED_NUM));

    // A mode change is treated exactly like an explicit restart.
    assign reload     = restart_i || (mode_i != mode_q);
    assign mode_valid = (mode_q <= MODE_BLINK);

    // ">=" rather than "==" so a step_ticks_i reduced mid-step takes effect
    // on the next tick instead of waiting for the counter to wrap.
    assign step_last   = (step_ticks_i == '0) ? '0 : step_ticks_i - STEP_W'(1);
    assign advance_due = (step_cnt >= step_last);

    led_tick_div #(
        .TICK_CNT (TICK_CNT)
    ) u_tick_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  ((state != ST_RUN) || !en_i || reload),
        .en_i   (state == ST_RUN),
        .tick_o (tick)
    );

    // Next pattern for the stored mode.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_pat      = '0;
        next_dir_down = dir_down;
        case (mode_q)
            MODE_SHIFT_UP: next_pat = {pat[LED_NUM-2:0], pat[LED_NUM-1]};
            MODE_SHIFT_DN: next_pat = {pat[0], pat[LED_NUM-1:1]};
            MODE_PINGPONG: begin
                next_pat = dir_down ? (pat >> 1) : (pat << 1);
                // Turn around on reaching an end so end LEDs are not repeated.
                if (next_pat[LED_NUM-1])  next_dir_down = 1'b1;
                else if (next_pat[0])     next_dir_down = 1'b0;
            end
            MODE_BAR:   next_pat = (&pat) ? '0 : {pat[LED_NUM-2:0], 1'b1};
            MODE_BLINK: next_pat = ~pat;
            default:    next_pat = '0;
        endcase
    end

    // NOTE: the flop reset is asynchronous (in the sensitivity list), so the
    // LEDs go dark the moment rst_n falls, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pat      <= '0;
            step_cnt <= '0;
            dir_down <= 1'b0;
            mode_q   <= '0;
            step_o   <= 1'b0;
            wrap_o   <= 1'b0;
        end else begin
            step_o <= 1'b0;
            wrap_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pat      <= '0;
                    step_cnt <= '0;
                    dir_down <= 1'b0;
                    if (en_i) begin
                        state  <= ST_RUN;
                        pat    <= init_new;
                        mode_q <= mode_i;
                    end
                end
                ST_RUN: begin
                    if (!en_i) begin
                        state    <= ST_IDLE;
                        pat      <= '0;
                        step_cnt <= '0;
                        dir_down <= 1'b0;
                    end else if (reload) begin
                        pat      <= init_new;
                        mode_q   <= mode_i;
                        dir_down <= 1'b0;
                        step_cnt <= '0;
                    end else if (tick) begin
                        if (advance_due) begin
                            step_cnt <= '0;
                            // Reserved modes keep counting but never advance.
                            if (mode_valid) begin
                                pat      <= next_pat;
                                dir_down <= next_dir_down;
                                step_o   <= 1'b1;
                                wrap_o   <= (next_pat == init_cur);
                            end
                        end else begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign led_o = LED_ON_MODE ? pat : ~pat;

endmodule

// File: tb/tb_led_pattern_seq.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_seq
// Drives two sequencers (active-high and active-low LEDs) with shared inputs.
// The driver advances a reference model once per clock and queues the
// outputs expected after that edge; a monitor on the falling edge pops one
// entry per cycle and compares it with both DUTs.
// The model describes each mode as a closed-form sequence indexed by the
// number of advances taken, plus elapsed-time bookkeeping for the timing.
// ---------------------------------------------------------------------------
module tb_led_pattern_seq;

    localparam int N        = 4;
    localparam int TICK_CNT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_i = 1'b0;
    logic [2:0]   mode_i = '0;
    logic [15:0]  step_ticks_i = '0;
    logic         restart_i = 1'b0;

    logic [N-1:0] led_hi, led_lo;
    logic         step_hi, wrap_hi, step_lo, wrap_lo;

    led_pattern_seq #(
        .LED_NUM(N), .LED_ON_MODE(1'b1), .CLK_FREQ(1_000_000), .TICK_US(2), .STEP_W(16)
    ) dut_hi (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i),
        .step_ticks_i(step_ticks_i), .restart_i(restart_i),
        .led_o(led_hi), .step_o(step_hi), .wrap_o(wrap_hi)
    );

    led_pattern_seq #(
        .LED_NUM(N), .LED_ON_MODE(1'b0), .CLK_FREQ(1_000_000), .TICK_US(2), .STEP_W(16)
    ) dut_lo (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .mode_i(mode_i),
        .step_ticks_i(step_ticks_i), .restart_i(restart_i),
        .led_o(led_lo), .step_o(step_lo), .wrap_o(wrap_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pat;
        logic         step;
        logic         wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // ---------------- reference model ----------------
    bit m_run   = 1'b0;
    int m_mode  = 0;
    int m_k     = 0;   // advances taken since the last (re)start
    int m_ph    = 0;   // clocks since prescaler was last cleared, mod TICK_CNT
    int m_tk    = 0;   // ticks since the last advance or clear

    function automatic int period(input int mode);
        case (mode)
            0, 1:    return N;
            2:       return 2 * (N - 1);
            3:       return N + 1;
            4:       return 2;
            default: return 1;
        endcase
    endfunction

    // Pattern after k advances in a mode.
    function automatic logic [N-1:0] pattern(input int mode, input int k);
        logic [N-1:0] r;
        int p, idx, c;
        r = '0;
        case (mode)
            0: r[k % N] = 1'b1;
            1: r[N - 1 - (k % N)] = 1'b1;
            2: begin
                p   = k % (2 * (N - 1));
                idx = (p < N) ? p : 2 * (N - 1) - p;
                r[idx] = 1'b1;
            end
            3: begin
                c = (k + 1) % (N + 1);
                for (int i = 0; i < N; i++) if (i < c) r[i] = 1'b1;
            end
            4: r = (k % 2 == 0) ? '1 : '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int max1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

    // Advance the model across one clock edge using the inputs currently held,
    // and queue what the DUT must show after that edge.
    task automatic model_step();
        exp_t e;
        e.step = 1'b0;
        e.wrap = 1'b0;
        if (!m_run) begin
            if (en_i) begin
                m_run = 1'b1; m_mode = int'(mode_i);
                m_k = 0; m_ph = 0; m_tk = 0;
            end
        end else if (!en_i) begin
            m_run = 1'b0;
        end else if (restart_i || int'(mode_i) != m_mode) begin
            m_mode = int'(mode_i);
            m_k = 0; m_ph = 0; m_tk = 0;
        end else begin
            if (m_ph == TICK_CNT - 1) begin
                m_tk++;
                if (m_tk >= max1(int'(step_ticks_i))) begin
                    m_tk = 0;
                    if (m_mode <= 4) begin
                        m_k++;
                        e.step = 1'b1;
                        e.wrap = (m_k % period(m_mode) == 0);
                    end
                end
            end
            m_ph = (m_ph + 1) % TICK_CNT;
        end
        e.pat = m_run ? pattern(m_mode, m_k) : '0;
        exp_q.push_back(e);
    endtask

    function automatic bit would_advance(input int st);
        return m_run && m_mode == 0 && (m_ph == TICK_CNT - 1) && (m_tk + 1 >= max1(st));
    endfunction

    task automatic push_reset();
        exp_t e;
        m_run = 1'b0;
        e.pat = '0; e.step = 1'b0; e.wrap = 1'b0;
        exp_q.push_back(e);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic drive(input logic en, input logic [2:0] mode,
                         input logic [15:0] st, input logic rs);
        en_i = en; mode_i = mode; step_ticks_i = st; restart_i = rs;
    endtask

    task automatic run(input int n, input logic en, input logic [2:0] mode,
                       input logic [15:0] st);
        repeat (n) begin
            next_cycle();
            drive(en, mode, st, 1'b0);
        end
    endtask

    // rst_n falls mid-cycle; outputs must be at reset values before the
    // next clock edge.
    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        drive(1'b0, 3'd0, 16'd0, 1'b0);
        push_reset();
        repeat (n - 1) begin
            @(posedge clk);
            #1;
            push_reset();
        end
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (led_hi !== e.pat || led_lo !== ~e.pat ||
                step_hi !== e.step || step_lo !== e.step ||
                wrap_hi !== e.wrap || wrap_lo !== e.wrap) begin
                n_err++;
                $display("FAIL outputs @%0t: led_hi=%b led_lo=%b step=%b/%b wrap=%b/%b, expected led=%b step=%b wrap=%b",
                         $time, led_hi, led_lo, step_hi, step_lo, wrap_hi, wrap_lo,
                         e.pat, e.step, e.wrap);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        bit found;
        logic [2:0] md;

        do_reset(3);

        // Rotate up, 3 ticks per step.
        run(30, 1'b1, 3'd0, 16'd3);
        // Ping-pong, 1 tick per step.
        run(20, 1'b1, 3'd2, 16'd1);
        // Bar fill, step_ticks 0 behaves as 1.
        run(16, 1'b1, 3'd3, 16'd0);
        // Rotate up to 0100, then switch to blink.
        run(5, 1'b1, 3'd0, 16'd1);
        run(6, 1'b1, 3'd4, 16'd1);
        // Rotate up to 0100, drop and re-raise enable.
        run(5, 1'b1, 3'd0, 16'd1);
        run(2, 1'b0, 3'd0, 16'd1);
        run(6, 1'b1, 3'd0, 16'd1);

        // Restart pulsed exactly in a cycle where an advance is due.
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            next_cycle();
            if (would_advance(3)) begin
                drive(1'b1, 3'd0, 16'd3, 1'b1);
                found = 1'b1;
            end else begin
                drive(1'b1, 3'd0, 16'd3, 1'b0);
            end
        end
        if (!found) begin
            n_err++;
            $display("FAIL restart_align: no advance slot within 50 cycles, expected one");
        end
        run(8, 1'b1, 3'd0, 16'd3);

        // Asynchronous reset mid-run, then a reserved mode.
        run(7, 1'b1, 3'd0, 16'd1);
        do_reset(2);
        run(12, 1'b1, 3'd6, 16'd1);

        // Randomised segments.
        for (int seg = 0; seg < 250; seg++) begin
            md = 3'($urandom_range(0, 11) % 8);
            if ($urandom_range(0, 39) == 0) begin
                do_reset(2);
            end
            for (int c = 0, len = $urandom_range(1, 30); c < len; c++) begin
                next_cycle();
                drive(($urandom_range(0, 9) != 0) || c > 0 ? en_i | (c == 0) : 1'b0,
                      md, 16'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
            end
            if ($urandom_range(0, 7) == 0) run(2, 1'b0, md, 16'd1);
        end

        run(2, 1'b0, 3'd0, 16'd1);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
